// File: rtl/axi_err_slave.sv
// AXI4 terminating responder: every write and read is completed with a fixed error response.
// The write and read channels run independent FSMs, with one transaction outstanding per direction.
module axi_err_slave #(
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 6,
  parameter int unsigned AXI_USER_WIDTH = 6,
  parameter logic [1:0]  RESP           = 2'b11,
  parameter logic [63:0] RDATA          = 64'hBADC0FFE
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  // write address
  input  logic                      aw_valid_i,
  input  logic [AXI_ID_WIDTH-1:0]   aw_id_i,
  input  logic [AXI_USER_WIDTH-1:0] aw_user_i,
  output logic                      aw_ready_o,
  // write data
  input  logic                      w_valid_i,
  input  logic                      w_last_i,
  output logic                      w_ready_o,
  // write response
  output logic                      b_valid_o,
  output logic [1:0]                b_resp_o,
  output logic [AXI_ID_WIDTH-1:0]   b_id_o,
  output logic [AXI_USER_WIDTH-1:0] b_user_o,
  input  logic                      b_ready_i,
  // read address
  input  logic                      ar_valid_i,
  input  logic [AXI_ID_WIDTH-1:0]   ar_id_i,
  input  logic [7:0]                ar_len_i,
  input  logic [AXI_USER_WIDTH-1:0] ar_user_i,
  output logic                      ar_ready_o,
  // read data
  output logic                      r_valid_o,
  output logic [AXI_DATA_WIDTH-1:0] r_data_o,
  output logic [1:0]                r_resp_o,
  output logic                      r_last_o,
  output logic [AXI_ID_WIDTH-1:0]   r_id_o,
  output logic [AXI_USER_WIDTH-1:0] r_user_o,
  input  logic                      r_ready_i
);

  localparam logic [AXI_DATA_WIDTH-1:0] RDataExt = AXI_DATA_WIDTH'(RDATA);

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic {RIdle, RData} r_state_e;

  w_state_e                  w_state_q, w_state_d;
  r_state_e                  r_state_q, r_state_d;
  logic [AXI_ID_WIDTH-1:0]   b_id_q, b_id_d, r_id_q, r_id_d;
  logic [AXI_USER_WIDTH-1:0] b_user_q, b_user_d, r_user_q, r_user_d;
  logic [7:0]                len_q, len_d, cnt_q, cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_state_q <= WIdle;
      r_state_q <= RIdle;
      b_id_q    <= '0;
      b_user_q  <= '0;
      r_id_q    <= '0;
      r_user_q  <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      b_id_q    <= b_id_d;
      b_user_q  <= b_user_d;
      r_id_q    <= r_id_d;
      r_user_q  <= r_user_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
    end
  end

  // W beats are only accepted after AW, so early data stalls instead of being lost
  always_comb begin
    w_state_d  = w_state_q;
    b_id_d     = b_id_q;
    b_user_d   = b_user_q;
    aw_ready_o = 1'b0;
    w_ready_o  = 1'b0;
    b_valid_o  = 1'b0;
    case (w_state_q)
      WIdle: begin
        aw_ready_o = 1'b1;
        if (aw_valid_i) begin
          b_id_d    = aw_id_i;
          b_user_d  = aw_user_i;
          w_state_d = WData;
        end
      end
      WData: begin
        w_ready_o = 1'b1;
        if (w_valid_i && w_last_i) w_state_d = WResp;
      end
      WResp: begin
        b_valid_o = 1'b1;
        if (b_ready_i) w_state_d = WIdle;
      end
      default: w_state_d = WIdle;
    endcase
  end

  always_comb begin
    r_state_d  = r_state_q;
    r_id_d     = r_id_q;
    r_user_d   = r_user_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    ar_ready_o = 1'b0;
    r_valid_o  = 1'b0;
    r_last_o   = 1'b0;
    case (r_state_q)
      RIdle: begin
        ar_ready_o = 1'b1;
        if (ar_valid_i) begin
          r_id_d    = ar_id_i;
          r_user_d  = ar_user_i;
          len_d     = ar_len_i;
          cnt_d     = '0;
          r_state_d = RData;
        end
      end
      RData: begin
        r_valid_o = 1'b1;
        r_last_o  = (cnt_q == len_q);
        // The counter stops at len, so a 256-beat burst never wraps it
        if (r_ready_i) begin
          if (r_last_o) r_state_d = RIdle;
          else          cnt_d     = cnt_q + 8'd1;
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  assign b_resp_o = RESP;
  assign b_id_o   = b_id_q;
  assign b_user_o = b_user_q;
  assign r_data_o = RDataExt;
  assign r_resp_o = RESP;
  assign r_id_o   = r_id_q;
  assign r_user_o = r_user_q;

endmodule

// File: tb/tb_axi_err_slave.sv
// Bench for axi_err_slave: directed scenarios followed by randomized transactions.
// A transaction-level model tracks the expected beat counts, ids and users.
module tb_axi_err_slave;

  localparam logic [63:0] ExpData = 64'hBADC0FFE;

  logic       clk = 1'b0;
  logic       rst;
  logic       aw_valid, aw_ready, w_valid, w_last, w_ready;
  logic [5:0] aw_id, aw_user, b_id, b_user, ar_id, ar_user, r_id, r_user;
  logic       b_valid, b_ready, ar_valid, ar_ready, r_valid, r_last, r_ready;
  logic [1:0] b_resp, r_resp;
  logic [7:0] ar_len;
  logic [63:0] r_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axi_err_slave dut (
    .clk_i(clk), .rst_i(rst),
    .aw_valid_i(aw_valid), .aw_id_i(aw_id), .aw_user_i(aw_user), .aw_ready_o(aw_ready),
    .w_valid_i(w_valid), .w_last_i(w_last), .w_ready_o(w_ready),
    .b_valid_o(b_valid), .b_resp_o(b_resp), .b_id_o(b_id), .b_user_o(b_user),
    .b_ready_i(b_ready),
    .ar_valid_i(ar_valid), .ar_id_i(ar_id), .ar_len_i(ar_len), .ar_user_i(ar_user),
    .ar_ready_o(ar_ready),
    .r_valid_o(r_valid), .r_data_o(r_data), .r_resp_o(r_resp), .r_last_o(r_last),
    .r_id_o(r_id), .r_user_o(r_user), .r_ready_i(r_ready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One read burst; the model expects exactly len+1 beats with last on the final one
  task automatic do_read(input logic [5:0] id, input logic [5:0] user, input int len,
                         input bit rnd);
    int  beat = 0;
    int  cyc  = 0;
    bit  done = 0;
    bit  hs;
    ar_valid = 1'b1; ar_id = id; ar_user = user; ar_len = 8'(len);
    chk("ar_ready_idle", {63'd0, ar_ready}, 64'd1);
    step();
    ar_valid = 1'b0; ar_id = '0; ar_user = '0; ar_len = '0;
    while (!done && cyc < 4000) begin
      r_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      chk("r_valid", {63'd0, r_valid}, 64'd1);
      chk("r_last", {63'd0, r_last}, {63'd0, beat == len});
      chk("r_id", {58'd0, r_id}, {58'd0, id});
      chk("r_user", {58'd0, r_user}, {58'd0, user});
      chk("r_data", r_data, ExpData);
      chk("r_resp", {62'd0, r_resp}, 64'd3);
      chk("ar_ready_busy", {63'd0, ar_ready}, 64'd0);
      hs = r_ready;
      step();
      cyc++;
      if (hs) begin
        if (beat == len) done = 1;
        beat++;
      end
    end
    r_ready = 1'b0;
    chk("r_beats", 64'(beat), 64'(len + 1));
    chk("r_valid_after", {63'd0, r_valid}, 64'd0);
    chk("ar_ready_after", {63'd0, ar_ready}, 64'd1);
  endtask

  // One write with nbeats data beats and random gaps; B is released after a random delay
  task automatic do_write(input logic [5:0] id, input logic [5:0] user, input int nbeats);
    int sent = 0;
    int cyc  = 0;
    bit hs;
    aw_valid = 1'b1; aw_id = id; aw_user = user;
    chk("aw_ready_idle", {63'd0, aw_ready}, 64'd1);
    step();
    aw_valid = 1'b0; aw_id = '0; aw_user = '0;
    while (sent < nbeats && cyc < 1000) begin
      w_valid = 1'($urandom_range(0, 1));
      w_last  = (sent == nbeats - 1);
      chk("w_ready", {63'd0, w_ready}, 64'd1);
      chk("b_valid_data", {63'd0, b_valid}, 64'd0);
      chk("aw_ready_busy", {63'd0, aw_ready}, 64'd0);
      hs = w_valid;
      step();
      cyc++;
      if (hs) sent++;
    end
    w_valid = 1'b0; w_last = 1'b0;
    cyc = 0;
    do begin
      b_ready = 1'($urandom_range(0, 1));
      chk("b_valid", {63'd0, b_valid}, 64'd1);
      chk("b_id", {58'd0, b_id}, {58'd0, id});
      chk("b_user", {58'd0, b_user}, {58'd0, user});
      chk("b_resp", {62'd0, b_resp}, 64'd3);
      chk("w_ready_resp", {63'd0, w_ready}, 64'd0);
      hs = b_ready;
      step();
      cyc++;
    end while (!hs && cyc < 1000);
    b_ready = 1'b0;
    chk("b_valid_after", {63'd0, b_valid}, 64'd0);
    chk("aw_ready_after", {63'd0, aw_ready}, 64'd1);
  endtask

  initial begin
    int  beat;
    bit  rd_active;
    rst = 1'b1;
    aw_valid = 0; aw_id = 0; aw_user = 0; w_valid = 0; w_last = 0; b_ready = 0;
    ar_valid = 0; ar_id = 0; ar_len = 0; ar_user = 0; r_ready = 0;
    step();
    chk("rst_aw_ready", {63'd0, aw_ready}, 64'd1);
    chk("rst_ar_ready", {63'd0, ar_ready}, 64'd1);
    chk("rst_w_ready", {63'd0, w_ready}, 64'd0);
    chk("rst_b_valid", {63'd0, b_valid}, 64'd0);
    chk("rst_r_valid", {63'd0, r_valid}, 64'd0);
    chk("rst_r_last", {63'd0, r_last}, 64'd0);
    chk("rst_b_id", {58'd0, b_id}, 64'd0);
    chk("rst_r_id", {58'd0, r_id}, 64'd0);
    rst = 1'b0;
    step();

    // 1: minimum-latency write
    aw_valid = 1; aw_id = 6'd5; aw_user = 6'd3;
    chk("t1_aw_ready", {63'd0, aw_ready}, 64'd1);
    step();
    aw_valid = 0; w_valid = 1; w_last = 1;
    chk("t1_w_ready", {63'd0, w_ready}, 64'd1);
    chk("t1_b_early", {63'd0, b_valid}, 64'd0);
    step();
    w_valid = 0; w_last = 0; b_ready = 1;
    chk("t1_b_valid", {63'd0, b_valid}, 64'd1);
    chk("t1_b_resp", {62'd0, b_resp}, 64'd3);
    chk("t1_b_id", {58'd0, b_id}, 64'd5);
    chk("t1_b_user", {58'd0, b_user}, 64'd3);
    step();
    b_ready = 0;
    chk("t1_b_done", {63'd0, b_valid}, 64'd0);

    // 2: four-beat read, 3: 256-beat read with random back-pressure
    do_read(6'd9, 6'd1, 3, 1'b0);
    do_read(6'd17, 6'd2, 255, 1'b1);

    // 4: W held before AW stalls until the cycle after the AW handshake
    w_valid = 1; w_last = 1;
    for (int i = 0; i < 3; i++) begin
      chk("t4_w_stall", {63'd0, w_ready}, 64'd0);
      step();
    end
    aw_valid = 1; aw_id = 6'd7; aw_user = 6'd4;
    chk("t4_w_stall_aw", {63'd0, w_ready}, 64'd0);
    step();
    aw_valid = 0;
    chk("t4_w_ready", {63'd0, w_ready}, 64'd1);
    step();
    w_valid = 0; w_last = 0; b_ready = 1;
    chk("t4_b_valid", {63'd0, b_valid}, 64'd1);
    chk("t4_b_id", {58'd0, b_id}, 64'd7);
    step();
    b_ready = 0;

    // 5: AW and AR together; read finishes while B is held off
    aw_valid = 1; aw_id = 6'd11; aw_user = 6'd12;
    ar_valid = 1; ar_id = 6'd13; ar_user = 6'd14; ar_len = 8'd2;
    chk("t5_aw_ready", {63'd0, aw_ready}, 64'd1);
    chk("t5_ar_ready", {63'd0, ar_ready}, 64'd1);
    step();
    aw_valid = 0; ar_valid = 0;
    beat = 0; rd_active = 1;
    for (int k = 0; k < 10; k++) begin
      w_valid = (k == 0); w_last = 1; r_ready = 1; b_ready = 0;
      chk("t5_r_valid", {63'd0, r_valid}, {63'd0, rd_active});
      if (rd_active) chk("t5_r_last", {63'd0, r_last}, {63'd0, beat == 2});
      chk("t5_b_valid", {63'd0, b_valid}, {63'd0, k != 0});
      step();
      if (rd_active) begin
        if (beat == 2) rd_active = 0;
        beat++;
      end
    end
    w_valid = 0; w_last = 0; r_ready = 0;
    chk("t5_r_beats", 64'(beat), 64'd3);
    chk("t5_b_hold", {63'd0, b_valid}, 64'd1);
    chk("t5_b_id", {58'd0, b_id}, 64'd11);
    b_ready = 1;
    step();
    b_ready = 0;
    chk("t5_b_done", {63'd0, b_valid}, 64'd0);

    // 6: reset mid-burst drops the read; a fresh single-beat read follows
    ar_valid = 1; ar_id = 6'd21; ar_len = 8'd7; ar_user = 6'd22;
    step();
    ar_valid = 0; r_ready = 1;
    step();
    step();
    chk("t6_mid_burst", {63'd0, r_valid}, 64'd1);
    r_ready = 0; rst = 1;
    #1;
    chk("t6_rst_r_valid", {63'd0, r_valid}, 64'd0);
    step();
    chk("t6_r_valid", {63'd0, r_valid}, 64'd0);
    chk("t6_ar_ready", {63'd0, ar_ready}, 64'd1);
    rst = 0;
    step();
    do_read(6'd23, 6'd24, 0, 1'b0);

    // Randomized traffic
    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 1) == 1)
        do_read(6'($urandom), 6'($urandom), int'($urandom_range(0, 15)), 1'b1);
      else
        do_write(6'($urandom), 6'($urandom), int'($urandom_range(1, 4)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
